key_event_scheduler: RTL
========================

# key_event_scheduler

Sequences the stable, already-debounced button levels of the front panel into a single ordered stream of key events. Detects press edges, generates auto-repeat events for held buttons, arbitrates round-robin between buttons that request in the same cycle, and buffers events in a small FIFO drained by a valid/ready consumer (menu/UI logic). Sits between the per-button debounce filters and the UI controller.

## Interface
- N_BTN, 4, number of buttons; legal 2..8
- HOLD_CYCLES, 50_000_000, cycles a button must stay high after its press event before the first repeat event (0.5 s at 100 MHz); ≥2
- REPEAT_CYCLES, 10_000_000, cycles between successive repeat events; ≥2
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16

- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- BTN  in  N_BTN  debounced button levels, 1 = pressed, synchronous to CLK
- EV_VALID  out  1  head of FIFO holds an event
- EV_READY  in  1  consumer accepts head event when EV_VALID & EV_READY
- EV_CODE  out  clog2(N_BTN)  button index of head event
- EV_REPEAT  out  1  0 = press event, 1 = auto-repeat event
- DROP  out  1  one-cycle pulse: an event request was lost

## Operation
- Per-button FSM, states IDLE, HELD, REPEAT; one shared-width counter per button, width clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
- Edge detect uses register BTN_PREV (resets to all ones: a button held through reset produces no event until released and re-pressed).
- IDLE: BTN[i]=1 & BTN_PREV[i]=0 → raise press request, counter←0, go HELD.
- HELD: BTN[i]=0 → IDLE. Else counter increments; at HOLD_CYCLES-1 → raise repeat request, counter←0, go REPEAT.
- REPEAT: BTN[i]=0 → IDLE. Else counter increments; at REPEAT_CYCLES-1 → raise repeat request, counter←0.
- Request = pending flag + repeat bit per button. Raising a request while that button's flag is already set: flag stays, repeat bit keeps old value, DROP pulses. Release does not clear a pending flag.
- Arbiter: one grant per cycle among set flags, round-robin starting at (last granted + 1) mod N_BTN; last-granted resets to N_BTN-1 (button 0 first). Grant only if FIFO can accept; granted flag clears, {index, repeat} written to FIFO. Flag clear and new raise for same button in same cycle: new request is kept, no DROP.
- FIFO accepts write when count < FIFO_DEPTH, or when full and a pop occurs the same cycle. Full with no pop: no grant, flags wait (no DROP from FIFO full alone).
- Pop when EV_VALID & EV_READY. EV_CODE/EV_REPEAT valid only while EV_VALID; stable while EV_VALID & !EV_READY.

## Timing
- Reset (nRST low, asynchronous): all FSMs IDLE, counters 0, flags 0, FIFO empty, EV_VALID=0, EV_CODE=0, EV_REPEAT=0, DROP=0, BTN_PREV=all ones. Asserting mid-operation discards all queued and pending events immediately.
- Press latency: BTN[i] first sampled high at edge k → flag set at k → FIFO write at k+1 (if granted) → EV_VALID=1 after edge k+1.
- First repeat request at edge k+HOLD_CYCLES; subsequent every REPEAT_CYCLES edges.
- Empty FIFO: write and EV_VALID rise the same edge; no bypass combinational path from BTN to outputs.
- DROP registered, high exactly one cycle per lost request.

## Test plan
- Single press: BTN=0001 for 10 cycles then 0 → exactly one event {CODE=0, REPEAT=0}, EV_VALID high 2 edges after first high sample; no repeats.
- Hold (HOLD=20, REPEAT=5): BTN[2] high 40 cycles, EV_READY=1 → press, repeat at +20, then repeats at +25, +30, +35, all CODE=2, REPEAT=1.
- Simultaneous: BTN 0000→1111 in one cycle, EV_READY=1 → codes 0,1,2,3 on consecutive cycles; repeat with 0→1010 next → order 1? no: pointer after 3 → codes 1,3.
- Backpressure: FIFO_DEPTH=4, EV_READY=0, six presses on different buttons → 4 queued, 2 flags pending, DROP never pulses; EV_READY=1 → all six delivered in arbitration order.
- Drop: EV_READY=0, FIFO full, button 1 held into repeat with REPEAT=5 → second repeat raise while flag set gives DROP one-cycle pulse.
- Reset mid-run: queue 3 events, pulse nRST low between edges with BTN[0] held → outputs 0 at once; after release no event until BTN[0] goes 0 then 1.

Source files
------------

// File: rtl/key_event_scheduler.sv
// Turns debounced front-panel button levels into an ordered stream of press and
// auto-repeat key events, arbitrated round-robin and queued for a valid/ready consumer.
module key_event_scheduler #(
    parameter int N_BTN         = 4,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [N_BTN-1:0]         BTN,
    output logic                     EV_VALID,
    input  logic                     EV_READY,
    output logic [$clog2(N_BTN)-1:0] EV_CODE,
    output logic                     EV_REPEAT,
    output logic                     DROP
);
    localparam int CODE_W  = $clog2(N_BTN);
    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [AW:0]       FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       COUNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]     PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_t;

    state_t             r_state     [N_BTN];
    state_t             w_state_nxt [N_BTN];
    logic [CNT_W-1:0]   r_cnt       [N_BTN];
    logic [CNT_W-1:0]   w_cnt_nxt   [N_BTN];
    logic [N_BTN-1:0]   r_btn_prev;
    logic [N_BTN-1:0]   r_flag;
    logic [N_BTN-1:0]   r_rep;
    logic [N_BTN-1:0]   w_raise;
    logic [N_BTN-1:0]   w_raise_rep;
    logic [N_BTN-1:0]   w_grant;
    logic [N_BTN-1:0]   w_accept;
    logic [CODE_W-1:0]  r_last;
    logic [CODE_W-1:0]  w_grant_idx;
    logic               w_grant_any;
    logic               r_drop;

    logic [CODE_W:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic               w_pop;
    logic               w_fifo_ok;
    logic [CODE_W:0]    w_head;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_raise[i]     = 1'b0;
            w_raise_rep[i] = 1'b0;
            case (r_state[i])
                S_IDLE: begin
                    if (BTN[i] && !r_btn_prev[i]) begin
                        w_raise[i]     = 1'b1;
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = S_HELD;
                    end
                end
                S_HELD: begin
                    if (!BTN[i]) begin
                        w_state_nxt[i] = S_IDLE;
                    end else if (r_cnt[i] == HOLD_LAST) begin
                        w_raise[i]     = 1'b1;
                        w_raise_rep[i] = 1'b1;
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = S_REPEAT;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                    end
                end
                S_REPEAT: begin
                    if (!BTN[i]) begin
                        w_state_nxt[i] = S_IDLE;
                    end else if (r_cnt[i] == REP_LAST) begin
                        w_raise[i]     = 1'b1;
                        w_raise_rep[i] = 1'b1;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                    end
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Round-robin search starts one past the last granted button.
    assign w_pop     = (r_count != '0) && EV_READY;
    assign w_fifo_ok = (r_count < FULL_CNT) || w_pop;

    always_comb begin : arb
        int                idx;
        logic [CODE_W-1:0] cand;
        idx         = 0;
        cand        = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        for (int off = 1; off <= N_BTN; off++) begin
            idx  = (int'(r_last) + off) % N_BTN;
            cand = CODE_W'(idx);
            if (w_fifo_ok && !w_grant_any && r_flag[cand]) begin
                w_grant_any   = 1'b1;
                w_grant_idx   = cand;
                w_grant[cand] = 1'b1;
            end
        end
    end

    // A raise is lost only when the flag is still set and not being granted this cycle.
    assign w_accept = w_raise & ~(r_flag & ~w_grant);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_btn_prev <= '1;
            r_flag     <= '0;
            r_rep      <= '0;
            r_drop     <= 1'b0;
            r_last     <= CODE_W'(N_BTN - 1);
        end else begin
            r_btn_prev <= BTN;
            r_flag     <= (r_flag & ~w_grant) | w_raise;
            r_rep      <= (r_rep & ~w_accept) | (w_raise_rep & w_accept);
            r_drop     <= |(w_raise & ~w_accept);
            if (w_grant_any) begin
                r_last <= w_grant_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_grant_any) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_grant_any, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_grant_any) begin
            r_mem[r_wr_ptr] <= {w_grant_idx, r_rep[w_grant_idx]};
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign EV_VALID  = (r_count != '0);
    assign EV_CODE   = EV_VALID ? w_head[CODE_W:1] : '0;
    assign EV_REPEAT = EV_VALID & w_head[0];
    assign DROP      = r_drop;

endmodule
